// File: rtl/step_cmd_pkg.sv
// step_cmd_pkg: shared types and constants for the step/dir command generator.
//   step_state_e    : engine FSM states
//   step_cmd_t      : decoded 32-bit command word (DIR, PERIOD, COUNT)
//   CMD_*           : bit positions of the command fields
//   DEF_*           : default STEP high time and DIR setup time
//   eff_period()    : clamps PERIOD so the LOW phase is never shorter than the HIGH phase
package step_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } step_state_e;

  localparam int CMD_DIR_BIT = 31;
  localparam int CMD_PER_MSB = 30;
  localparam int CMD_PER_LSB = 16;
  localparam int CMD_CNT_MSB = 15;
  localparam int CMD_CNT_LSB = 0;

  localparam int DEF_PULSE_WIDTH = 4;
  localparam int DEF_DIR_SETUP   = 2;

  typedef struct packed {
    logic        dir;
    logic [14:0] period;
    logic [15:0] count;
  } step_cmd_t;

  // PER = max(PERIOD, 2*PULSE_WIDTH), unsigned
  function automatic logic [15:0] eff_period(input logic [14:0] period,
                                             input int pulse_width);
    logic [15:0] min_per;
    logic [15:0] p;
    min_per = 16'(2 * pulse_width);
    p       = {1'b0, period};
    return (p > min_per) ? p : min_per;
  endfunction

endpackage

// File: rtl/step_cmd_fifo.sv
// step_cmd_fifo: synchronous first-word-fall-through FIFO for step commands.
//   CLK, RST_N : clock, async active-low reset
//   push       : enqueue wr_data (ignored when full or flushing)
//   pop        : dequeue head (ignored when empty or flushing)
//   flush      : drop all entries this cycle; wins over push and pop
//   rd_data    : current head entry (valid when !empty)
//   full/empty : derived from the registered level
//   level      : number of entries queued
module step_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  // full comes from a register, so a push while full is dropped even if a
  // pop frees a slot in the same cycle
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full  & ~flush;
  assign do_pop  = pop  & ~empty & ~flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/step_cmd_gen.sv
// step_cmd_gen: queues 32-bit motion commands from PCI IO writes and turns each
// into a STEP/DIR pulse train for one axis driver.
//   CLK, RST_N    : PCI clock, async active-low reset
//   WR_EN/WR_DATA : command write; [31]=DIR, [30:16]=PERIOD, [15:0]=COUNT
//   ENABLE        : engine may pop new commands
//   ABORT         : flush queue, stop after any in-flight STEP pulse
//   STEP_O/DIR_O  : axis driver outputs
//   BUSY          : engine not idle
//   DONE_PULSE    : one cycle per completed command (never on abort)
//   FIFO_FULL/FIFO_EMPTY/FIFO_LEVEL : queue status
//   OVERFLOW      : sticky, write seen while full; cleared by ABORT
//   POSITION      : signed step position
// Build option: define STEP_POSITION_COUNTER_EN to build the position counter;
// otherwise POSITION is tied to zero.
module step_cmd_gen
  import step_cmd_pkg::*;
#(
  parameter int FIFO_AW     = 2,
  parameter int PULSE_WIDTH = DEF_PULSE_WIDTH,
  parameter int DIR_SETUP   = DEF_DIR_SETUP
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WR_EN,
  input  logic [31:0]      WR_DATA,
  input  logic             ENABLE,
  input  logic             ABORT,
  output logic             STEP_O,
  output logic             DIR_O,
  output logic             BUSY,
  output logic             DONE_PULSE,
  output logic             FIFO_FULL,
  output logic             FIFO_EMPTY,
  output logic [FIFO_AW:0] FIFO_LEVEL,
  output logic             OVERFLOW,
  output logic [31:0]      POSITION
);
  localparam logic [15:0] PW_LAST = 16'(PULSE_WIDTH - 1);
  localparam logic [15:0] DS_LAST = 16'(DIR_SETUP - 1);

  step_state_e state, state_nxt;
  logic [31:0] fifo_rd;
  step_cmd_t   head;
  logic        pop_go;
  logic [15:0] tmr, per_q, cnt_q, low_last;
  logic        dir_q, done_q, abort_pend, ovf_q;
  logic        hi_end, low_end;

  step_cmd_fifo #(.WIDTH(32), .AW(FIFO_AW)) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .push    (WR_EN),
    .wr_data (WR_DATA),
    .pop     (pop_go),
    .flush   (ABORT),
    .rd_data (fifo_rd),
    .full    (FIFO_FULL),
    .empty   (FIFO_EMPTY),
    .level   (FIFO_LEVEL)
  );

  assign head.dir    = fifo_rd[CMD_DIR_BIT];
  assign head.period = fifo_rd[CMD_PER_MSB:CMD_PER_LSB];
  assign head.count  = fifo_rd[CMD_CNT_MSB:CMD_CNT_LSB];

  assign pop_go   = (state == ST_IDLE) & ENABLE & ~FIFO_EMPTY & ~ABORT;
  assign low_last = per_q - 16'(PULSE_WIDTH) - 16'd1;
  assign hi_end   = (tmr == PW_LAST);
  assign low_end  = (tmr == low_last);

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (pop_go && head.count != '0)
          state_nxt = (head.dir != dir_q) ? ST_SETUP : ST_HIGH;
      ST_SETUP:
        if (ABORT)                state_nxt = ST_IDLE;
        else if (tmr == DS_LAST)  state_nxt = ST_HIGH;
      // an abort during HIGH is remembered so the pulse is never cut short
      ST_HIGH:
        if (hi_end) state_nxt = (ABORT || abort_pend) ? ST_IDLE : ST_LOW;
      ST_LOW:
        if (ABORT)        state_nxt = ST_IDLE;
        else if (low_end) state_nxt = (cnt_q == 16'd1) ? ST_IDLE : ST_HIGH;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    STEP_O = (state == ST_HIGH);
    BUSY   = (state != ST_IDLE);
  end

  assign DIR_O      = dir_q;
  assign DONE_PULSE = done_q;
  assign OVERFLOW   = ovf_q;

  // datapath
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmr        <= '0;
      per_q      <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
      abort_pend <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      // per-state dwell counter, restarts on every state change
      tmr <= (state_nxt != state || state == ST_IDLE) ? '0 : tmr + 16'd1;

      if (pop_go) begin
        per_q <= eff_period(head.period, PULSE_WIDTH);
        cnt_q <= head.count;
        if (head.count != '0) dir_q <= head.dir;
      end else if (state == ST_LOW && low_end && !ABORT) begin
        cnt_q <= cnt_q - 16'd1;
      end

      done_q <= (pop_go && head.count == '0) ||
                (state == ST_LOW && low_end && !ABORT && cnt_q == 16'd1);

      abort_pend <= (state == ST_HIGH) && (state_nxt == ST_HIGH) &&
                    (ABORT || abort_pend);

      if (ABORT)                   ovf_q <= 1'b0;
      else if (WR_EN && FIFO_FULL) ovf_q <= 1'b1;
    end
  end

`ifdef STEP_POSITION_COUNTER_EN
  logic [31:0] pos_q;
  // dir_q already holds the command direction on every entry into HIGH
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pos_q <= '0;
    else if (state_nxt == ST_HIGH && state != ST_HIGH)
      pos_q <= dir_q ? pos_q - 32'd1 : pos_q + 32'd1;
  end
  assign POSITION = pos_q;
`else
  assign POSITION = '0;
`endif

endmodule

// File: tb/tb_step_cmd_gen.sv
// tb_step_cmd_gen: scoreboard bench for step_cmd_gen. Expected STEP pulses and
// DONE pulses are queued as commands are written; a negedge monitor pops and
// compares them as the DUT produces them.
module tb_step_cmd_gen;
  localparam int PW = 4;

  logic        CLK = 1'b0, RST_N = 1'b0, WR_EN = 1'b0, ENABLE = 1'b0, ABORT = 1'b0;
  logic [31:0] WR_DATA = '0;
  logic        STEP_O, DIR_O, BUSY, DONE_PULSE, FIFO_FULL, FIFO_EMPTY, OVERFLOW;
  logic [2:0]  FIFO_LEVEL;
  logic [31:0] POSITION;

  step_cmd_gen #(.FIFO_AW(2), .PULSE_WIDTH(PW), .DIR_SETUP(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .ENABLE(ENABLE), .ABORT(ABORT), .STEP_O(STEP_O), .DIR_O(DIR_O),
    .BUSY(BUSY), .DONE_PULSE(DONE_PULSE), .FIFO_FULL(FIFO_FULL),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW),
    .POSITION(POSITION)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit is_done;
    int gap;
    bit dir;
    int pos;
  } ev_t;

  ev_t sb[$];
  int  n_chk = 0, n_fail = 0;
  int  model_pos = 0;
  int  cyc = 0, rise_cyc = 0, last_rise = -1, obs_gap = -1;
  bit  in_pulse = 1'b0, rise_dir = 1'b0;
  logic [31:0] rise_pos = '0;
  int  k;

  function automatic int exp_pos(input int p);
`ifdef STEP_POSITION_COUNTER_EN
    return p;
`else
    return 0 * p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] d);
    @(posedge CLK); #1;
    WR_EN = 1'b1; WR_DATA = d;
    @(posedge CLK); #1;
    WR_EN = 1'b0;
  endtask

  // queue the expected pulses of one command followed by its DONE
  task automatic push_cmd(input bit dir, input int per, input int cnt, input int first_gap);
    ev_t e;
    for (int i = 0; i < cnt; i++) begin
      model_pos += dir ? -1 : 1;
      e.is_done = 1'b0;
      e.gap     = (i == 0) ? first_gap : per;
      e.dir     = dir;
      e.pos     = exp_pos(model_pos);
      sb.push_back(e);
    end
    e.is_done = 1'b1; e.gap = -1; e.dir = 1'b0; e.pos = 0;
    sb.push_back(e);
  endtask

  task automatic drain(input int max);
    int n = 0;
    do begin
      @(negedge CLK); #1;
      n++;
    end while ((sb.size() != 0 || BUSY) && n < max);
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic wait_step(input string tag);
    int n = 0;
    while (!STEP_O && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, STEP_O, 1'b1);
  endtask

  task automatic rst_chk(input string p);
    chk({p, "_step"},  STEP_O, 1'b0);
    chk({p, "_dir"},   DIR_O, 1'b0);
    chk({p, "_busy"},  BUSY, 1'b0);
    chk({p, "_done"},  DONE_PULSE, 1'b0);
    chk({p, "_empty"}, FIFO_EMPTY, 1'b1);
    chk({p, "_full"},  FIFO_FULL, 1'b0);
    chk({p, "_level"}, FIFO_LEVEL, 3'd0);
    chk({p, "_ovf"},   OVERFLOW, 1'b0);
    chk({p, "_pos"},   POSITION, 32'd0);
  endtask

  // monitor: one event per completed STEP pulse and per DONE cycle
  always @(negedge CLK) begin
    ev_t e;
    cyc++;
    if (!RST_N) begin
      in_pulse  = 1'b0;
      last_rise = -1;
    end else begin
      if (STEP_O && !in_pulse) begin
        in_pulse  = 1'b1;
        obs_gap   = (last_rise < 0) ? -1 : cyc - last_rise;
        last_rise = cyc;
        rise_cyc  = cyc;
        rise_dir  = DIR_O;
        rise_pos  = POSITION;
      end else if (!STEP_O && in_pulse) begin
        in_pulse = 1'b0;
        if (sb.size() == 0) chk("unexpected_step", 1, 0);
        else begin
          e = sb.pop_front();
          chk("ev_is_step", e.is_done, 1'b0);
          chk("step_width", cyc - rise_cyc, PW);
          if (e.gap >= 0) chk("step_gap", obs_gap, e.gap);
          chk("step_dir", rise_dir, e.dir);
          chk("step_pos", rise_pos, e.pos);
        end
      end
      if (DONE_PULSE) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("ev_is_done", e.is_done, 1'b1);
        end
      end
    end
  end

  initial begin
    // reset state
    repeat (3) @(posedge CLK);
    #1;
    rst_chk("rst");
    RST_N = 1'b1; ENABLE = 1'b1;
    @(posedge CLK); #1;

    // 3 steps, PERIOD 16, forward
    push_cmd(1'b0, 16, 3, -1);
    wr(32'h0010_0003);
    k = 0;
    @(negedge CLK);
    while (!STEP_O && k < 10) begin @(negedge CLK); k++; end
    chk("pop_to_step", k, 1);
    drain(200);
    chk("t1_pos", POSITION, exp_pos(model_pos));
    chk("t1_empty", FIFO_EMPTY, 1'b1);

    // reverse direction: DIR setup delay before first STEP
    push_cmd(1'b1, 16, 2, -1);
    wr(32'h8010_0002);
    k = 0;
    while (!DIR_O && k < 10) begin @(negedge CLK); k++; end
    chk("dir_seen", DIR_O, 1'b1);
    k = 0;
    while (!STEP_O && k < 10) begin @(negedge CLK); k++; end
    chk("dir_to_step", k, 2);
    drain(200);
    chk("t2_pos", POSITION, exp_pos(model_pos));

    // PERIOD 3 clamps to 8
    push_cmd(1'b0, 8, 2, -1);
    wr(32'h0003_0002);
    drain(200);
    chk("t3_pos", POSITION, exp_pos(model_pos));

    // fill while disabled, 5th word overflows and is dropped
    ENABLE = 1'b0;
    for (int i = 0; i < 4; i++) wr({1'b0, 15'(9 + i), 16'd1});
    wr({1'b0, 15'd20, 16'd2});
    @(negedge CLK);
    chk("t4_level", FIFO_LEVEL, 3'd4);
    chk("t4_full", FIFO_FULL, 1'b1);
    chk("t4_ovf", OVERFLOW, 1'b1);
    chk("t4_busy", BUSY, 1'b0);
    // one idle cycle between commands: rise-to-rise = previous PER + 1
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 9 + i, 1, (i == 0) ? -1 : 9 + i);
    ENABLE = 1'b1;
    drain(400);
    chk("t4_ovf_sticky", OVERFLOW, 1'b1);
    chk("t4_empty", FIFO_EMPTY, 1'b1);
    chk("t4_pos", POSITION, exp_pos(model_pos));

    // abort in 2nd HIGH cycle with 2 commands queued
    ENABLE = 1'b0;
    wr(32'h0010_0005);
    wr(32'h0010_0005);
    begin
      ev_t e;
      model_pos += 1;
      e.is_done = 1'b0; e.gap = -1; e.dir = 1'b0; e.pos = exp_pos(model_pos);
      sb.push_back(e);
    end
    ENABLE = 1'b1;
    wait_step("t5_step_seen");
    @(posedge CLK); #1; ABORT = 1'b1;
    @(posedge CLK); #1; ABORT = 1'b0;
    @(negedge CLK);
    chk("t5_no_runt", STEP_O, 1'b1);
    chk("t5_flushed", FIFO_EMPTY, 1'b1);
    repeat (40) @(negedge CLK);
    #1;
    chk("t5_busy", BUSY, 1'b0);
    chk("t5_level", FIFO_LEVEL, 3'd0);
    chk("t5_ovf_clr", OVERFLOW, 1'b0);
    chk("t5_sb", sb.size(), 0);
    chk("t5_pos", POSITION, exp_pos(model_pos));

    // COUNT=0: DONE one cycle after pop, no STEP
    begin
      ev_t e;
      e.is_done = 1'b1; e.gap = -1; e.dir = 1'b0; e.pos = 0;
      sb.push_back(e);
    end
    wr(32'h0010_0000);
    k = 0;
    @(negedge CLK);
    while (!DONE_PULSE && k < 5) begin @(negedge CLK); k++; end
    chk("done_lat", k, 1);
    drain(20);
    chk("t6_dir", DIR_O, 1'b0);
    chk("t6_pos", POSITION, exp_pos(model_pos));

    // reset mid-HIGH drops STEP at once
    wr(32'h0010_0002);
    wait_step("t7_step_seen");
    #2 RST_N = 1'b0;
    #1;
    model_pos = 0;
    rst_chk("midrst");
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_step", STEP_O, 1'b0);
    chk("post_rst_busy", BUSY, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
